// File: rtl/packet_arb_pkg.sv
// Shared types and helpers for the packet round-robin arbiter.
package packet_arb_pkg;

  typedef enum logic [0:0] {IDLE, BURST} arb_state_t;

  // Modulo-n increment; safe for non-power-of-two n.
  function automatic int unsigned rr_next(int unsigned idx, int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping at n_ports.
module rr_picker
  import packet_arb_pkg::*;
#(
  parameter int unsigned n_ports = 4,
  localparam int unsigned idx_w = $clog2(n_ports)
) (
  input  logic [n_ports-1:0] req,
  input  logic [idx_w-1:0]   ptr,
  output logic               gnt_valid,
  output logic [idx_w-1:0]   gnt_idx
);

  always_comb begin
    int unsigned idx;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 32'(ptr);
    for (int unsigned off = 0; off < n_ports; off++) begin
      if (!gnt_valid && req[idx_w'(idx)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx_w'(idx);
      end
      idx = rr_next(idx, n_ports);
    end
  end

endmodule

// File: rtl/packet_rr_arbiter.sv
// Packet-atomic round-robin arbiter: n_ports last-delimited streams onto one registered
// stream tagged with first/last/port.
module packet_rr_arbiter
  import packet_arb_pkg::*;
#(
  parameter int unsigned width   = 8,
  parameter int unsigned n_ports = 4,
  localparam int unsigned idx_w = $clog2(n_ports)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [n_ports-1:0]         up_valid,
  input  logic [n_ports-1:0]         up_last,
  input  logic [n_ports*width-1:0]   up_data,
  output logic [n_ports-1:0]         up_ready,
  output logic                       down_valid,
  output logic                       down_first,
  output logic                       down_last,
  output logic [width-1:0]           down_data,
  output logic [idx_w-1:0]           down_port,
  input  logic                       down_ready
);

  arb_state_t       state;
  logic [idx_w-1:0] rr_ptr;
  logic [idx_w-1:0] grant;
  logic [idx_w-1:0] sel;
  logic [idx_w-1:0] gnt_idx;
  logic             gnt_valid;
  logic             can_accept;
  logic             load;
  logic             load_first;
  logic             load_last;
  logic [width-1:0] load_data;

  rr_picker #(
    .n_ports(n_ports)
  ) u_picker (
    .req      (up_valid),
    .ptr      (rr_ptr),
    .gnt_valid(gnt_valid),
    .gnt_idx  (gnt_idx)
  );

  assign can_accept = !down_valid || down_ready;

  always_comb begin
    up_ready   = '0;
    load       = 1'b0;
    load_first = 1'b0;
    sel        = grant;
    if (!reset) begin
      unique case (state)
        IDLE: begin
          sel = gnt_idx;
          if (gnt_valid && can_accept) begin
            up_ready[gnt_idx] = 1'b1;
            load              = 1'b1;
            load_first        = 1'b1;
          end
        end
        BURST: begin
          // Owner keeps the output until its last beat; a bubble just loads nothing.
          up_ready[grant] = can_accept;
          load            = can_accept && up_valid[grant];
        end
        default: ;
      endcase
    end
    load_data = up_data[32'(sel)*width +: width];
    load_last = up_last[sel];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      grant      <= '0;
      down_valid <= 1'b0;
      down_first <= 1'b0;
      down_last  <= 1'b0;
      down_data  <= '0;
      down_port  <= '0;
    end else if (load) begin
      down_valid <= 1'b1;
      down_first <= load_first;
      down_last  <= load_last;
      down_data  <= load_data;
      down_port  <= sel;
      if (load_last) begin
        state  <= IDLE;
        rr_ptr <= idx_w'(rr_next(32'(sel), n_ports));
      end else begin
        state <= BURST;
        grant <= sel;
      end
    end else if (down_ready) begin
      down_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_packet_rr_arbiter.sv
// Directed self-checking bench: vector table on a 4-port arbiter plus hand sequences
// for 3-port wrap and asynchronous reset mid-packet.
module tb_packet_rr_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  always #5 clock = ~clock;

  // 4-port instance
  logic [3:0]  up_valid, up_last, up_ready;
  logic [31:0] up_data;
  logic        down_valid, down_first, down_last, down_ready;
  logic [7:0]  down_data;
  logic [1:0]  down_port;

  // 3-port instance
  logic [2:0]  t3_valid, t3_last, t3_ready;
  logic [23:0] t3_data;
  logic        t3_dvalid, t3_dfirst, t3_dlast, t3_dready;
  logic [7:0]  t3_ddata;
  logic [1:0]  t3_dport;

  packet_rr_arbiter #(.width(8), .n_ports(4)) dut4 (
    .clock(clock), .reset(reset), .up_valid(up_valid), .up_last(up_last), .up_data(up_data),
    .up_ready(up_ready), .down_valid(down_valid), .down_first(down_first),
    .down_last(down_last), .down_data(down_data), .down_port(down_port),
    .down_ready(down_ready)
  );

  packet_rr_arbiter #(.width(8), .n_ports(3)) dut3 (
    .clock(clock), .reset(reset), .up_valid(t3_valid), .up_last(t3_last), .up_data(t3_data),
    .up_ready(t3_ready), .down_valid(t3_dvalid), .down_first(t3_dfirst),
    .down_last(t3_dlast), .down_data(t3_ddata), .down_port(t3_dport),
    .down_ready(t3_dready)
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  typedef struct {
    logic [3:0]  v;
    logic [3:0]  l;
    logic [31:0] d;
    logic        dr;
    logic [3:0]  rdy;
    logic        dv;
    logic        df;
    logic        dl;
    logic [7:0]  dd;
    logic [1:0]  dp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [3:0] v, logic [3:0] l, logic [31:0] d, logic dr,
                              logic [3:0] rdy, logic dv, logic df, logic dl,
                              logic [7:0] dd, logic [1:0] dp);
    vec_t x;
    x.v = v; x.l = l; x.d = d; x.dr = dr; x.rdy = rdy;
    x.dv = dv; x.df = df; x.dl = dl; x.dd = dd; x.dp = dp;
    return x;
  endfunction

  initial begin
    // All four ports with continuous single-beat packets: grants 0,1,2,3,0
    vecs.push_back(mk(4'hF, 4'hF, 32'h40302010, 1, 4'b0001, 1, 1, 1, 8'h10, 0));
    vecs.push_back(mk(4'hF, 4'hF, 32'h41312111, 1, 4'b0010, 1, 1, 1, 8'h21, 1));
    vecs.push_back(mk(4'hF, 4'hF, 32'h42322212, 1, 4'b0100, 1, 1, 1, 8'h32, 2));
    vecs.push_back(mk(4'hF, 4'hF, 32'h43332313, 1, 4'b1000, 1, 1, 1, 8'h43, 3));
    vecs.push_back(mk(4'hF, 4'hF, 32'h44342414, 1, 4'b0001, 1, 1, 1, 8'h14, 0));
    // Port 0 three-beat packet
    vecs.push_back(mk(4'h1, 4'h0, 32'h000000A1, 1, 4'b0001, 1, 1, 0, 8'hA1, 0));
    vecs.push_back(mk(4'h1, 4'h0, 32'h000000A2, 1, 4'b0001, 1, 0, 0, 8'hA2, 0));
    vecs.push_back(mk(4'h1, 4'h1, 32'h000000A3, 1, 4'b0001, 1, 0, 1, 8'hA3, 0));
    vecs.push_back(mk(4'h0, 4'h0, 32'h00000000, 1, 4'b0000, 0, 0, 0, 8'h00, 0));
    // Port 1 four beats; port 2 waits from beat 3 on
    vecs.push_back(mk(4'h2, 4'h0, 32'h0000C100, 1, 4'b0010, 1, 1, 0, 8'hC1, 1));
    vecs.push_back(mk(4'h2, 4'h0, 32'h0000C200, 1, 4'b0010, 1, 0, 0, 8'hC2, 1));
    vecs.push_back(mk(4'h6, 4'h4, 32'h00D1C300, 1, 4'b0010, 1, 0, 0, 8'hC3, 1));
    vecs.push_back(mk(4'h6, 4'h6, 32'h00D1C400, 1, 4'b0010, 1, 0, 1, 8'hC4, 1));
    vecs.push_back(mk(4'h4, 4'h4, 32'h00D10000, 1, 4'b0100, 1, 1, 1, 8'hD1, 2));
    // Port 3 two-beat packet with 5 cycles of backpressure; port 0 also requesting
    vecs.push_back(mk(4'h8, 4'h0, 32'hE1000000, 1, 4'b1000, 1, 1, 0, 8'hE1, 3));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(4'h9, 4'h9, 32'hE20000B0, 0, 4'b0000, 1, 1, 0, 8'hE1, 3));
    vecs.push_back(mk(4'h9, 4'h9, 32'hE20000B0, 1, 4'b1000, 1, 0, 1, 8'hE2, 3));
    vecs.push_back(mk(4'h1, 4'h1, 32'h000000B0, 1, 4'b0001, 1, 1, 1, 8'hB0, 0));
    vecs.push_back(mk(4'h0, 4'h0, 32'h00000000, 1, 4'b0000, 0, 0, 0, 8'h00, 0));

    reset = 1'b1;
    up_valid = 4'hF; up_last = 4'hF; up_data = 32'h0; down_ready = 1'b1;
    t3_valid = 3'b0; t3_last = 3'b0; t3_data = 24'h0; t3_dready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("reset up_ready", 32'(up_ready), 32'h0);
    check("reset down_valid", 32'(down_valid), 32'h0);
    check("reset first/last", {30'h0, down_first, down_last}, 32'h0);
    check("reset data/port", {22'h0, down_data, down_port}, 32'h0);
    @(negedge clock);
    up_valid = 4'h0; up_last = 4'h0;
    reset = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clock);
      up_valid = vecs[i].v; up_last = vecs[i].l; up_data = vecs[i].d;
      down_ready = vecs[i].dr;
      #1;
      check($sformatf("vec%0d up_ready", i), 32'(up_ready), 32'(vecs[i].rdy));
      @(posedge clock);
      #1;
      check($sformatf("vec%0d down_valid", i), 32'(down_valid), 32'(vecs[i].dv));
      if (vecs[i].dv) begin
        check($sformatf("vec%0d first/last", i), {30'h0, down_first, down_last},
              {30'h0, vecs[i].df, vecs[i].dl});
        check($sformatf("vec%0d data", i), 32'(down_data), 32'(vecs[i].dd));
        check($sformatf("vec%0d port", i), 32'(down_port), 32'(vecs[i].dp));
      end
    end

    // 3-port wrap: port 1 packet moves ptr to 2, then ports 0 and 2 alternate 2,0,2
    @(negedge clock);
    t3_valid = 3'b010; t3_last = 3'b010; t3_data = 24'h232221;
    @(posedge clock); #1;
    check("n3 pre port", 32'(t3_dport), 32'd1);
    begin
      logic [1:0]  exp_port [3] = '{2'd2, 2'd0, 2'd2};
      logic [7:0]  exp_data [3] = '{8'h33, 8'h41, 8'h53};
      logic [23:0] vec_data [3] = '{24'h333231, 24'h434241, 24'h535251};
      for (int k = 0; k < 3; k++) begin
        @(negedge clock);
        t3_valid = 3'b101; t3_last = 3'b101; t3_data = vec_data[k];
        #1;
        check($sformatf("n3 step%0d up_ready", k), 32'(t3_ready),
              32'(3'b001 << exp_port[k]));
        @(posedge clock); #1;
        check($sformatf("n3 step%0d port", k), 32'(t3_dport), 32'(exp_port[k]));
        check($sformatf("n3 step%0d data", k), 32'(t3_ddata), 32'(exp_data[k]));
        check($sformatf("n3 step%0d first/last", k), {30'h0, t3_dfirst, t3_dlast}, 32'h3);
      end
    end
    @(negedge clock);
    t3_valid = 3'b0; t3_last = 3'b0;

    // Asynchronous reset in the middle of a port 3 burst
    up_valid = 4'h8; up_last = 4'h0; up_data = 32'hF1000000; down_ready = 1'b1;
    @(posedge clock); #1;
    check("burst start port", 32'(down_port), 32'd3);
    @(negedge clock);
    up_data = 32'hF2000000; down_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("async reset down_valid", 32'(down_valid), 32'h0);
    check("async reset up_ready", 32'(up_ready), 32'h0);
    @(posedge clock); #1;
    check("held reset down_valid", 32'(down_valid), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    up_last = 4'h8; up_data = 32'hF3000000; down_ready = 1'b1;
    #1;
    check("post reset up_ready", 32'(up_ready), 32'h8);
    @(posedge clock); #1;
    check("post reset first/last", {30'h0, down_first, down_last}, 32'h3);
    check("post reset data", 32'(down_data), 32'hF3);
    check("post reset port", 32'(down_port), 32'd3);
    @(negedge clock);
    up_valid = 4'h0; up_last = 4'h0;
    repeat (2) @(posedge clock);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
